// File: rtl/universal_shift_register_seq_if.sv
// Control and status bundle for the sequenced universal shift register.
// Master drives the op/data/sequencer inputs; slave returns register contents and run status.
interface universal_shift_register_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic             start;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, op, d, sin_r, sin_l, start, n,
        input  q, q_bar, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, op, d, sin_r, sin_l, start, n,
        output q, q_bar, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/universal_shift_register_seq.sv
// WIDTH-bit universal shift register with a start-triggered N-step shift sequencer.
// Latency: q updates on the edge an op/start is sampled; a run of n shifts completes n edges after start, done one cycle later.
// No backpressure: start/en are ignored while busy; a new start is accepted in the done (FIN) cycle.
module universal_shift_register_seq #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                          clk,
    input logic                          rst,
    universal_shift_register_seq_if.slave bus
);
    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [2:0]       op_lat, op_lat_nxt;
    logic             busy_reg, done_reg;

    function automatic logic [WIDTH-1:0] step(input logic [2:0] op,
                                              input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] din,
                                              input logic sr, input logic sl);
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            OP_HOLD:  r = cur;
            OP_LOAD:  r = din;
            OP_SHL:   r = {cur[WIDTH-2:0], sr};
            OP_SHR:   r = {sl, cur[WIDTH-1:1]};
            OP_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            OP_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_CLEAR: r = '0;
            default:  r = cur;
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

    always_comb begin
        state_nxt     = state;
        q_nxt         = q_reg;
        remaining_nxt = remaining;
        op_lat_nxt    = op_lat;
        case (state)
            RUN: begin
                // Latched op, live serial inputs; everything else on the bus is ignored.
                q_nxt         = step(op_lat, q_reg, bus.d, bus.sin_r, bus.sin_l);
                remaining_nxt = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state_nxt = FIN;
                end
            end
            default: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    op_lat_nxt = bus.op;
                    state_nxt  = FIN;
                    if (bus.n != '0) begin
                        q_nxt = step(bus.op, q_reg, bus.d, bus.sin_r, bus.sin_l);
                        if (is_shift(bus.op) && (bus.n != CNT_W'(1))) begin
                            remaining_nxt = bus.n - CNT_W'(1);
                            state_nxt     = RUN;
                        end
                    end
                end else if (bus.en) begin
                    q_nxt = step(bus.op, q_reg, bus.d, bus.sin_r, bus.sin_l);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q_reg     <= RESET_VAL;
            remaining <= '0;
            op_lat    <= OP_HOLD;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_nxt;
            q_reg     <= q_nxt;
            remaining <= remaining_nxt;
            op_lat    <= op_lat_nxt;
            busy_reg  <= (state_nxt == RUN);
            done_reg  <= (state_nxt == FIN);
        end
    end

    assign bus.q      = q_reg;
    assign bus.q_bar  = ~q_reg;
    assign bus.sout_l = q_reg[WIDTH-1];
    assign bus.sout_r = q_reg[0];
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Directed bench: expected q values are queued as stimulus is driven and popped after each edge.
module tb_universal_shift_register_seq;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    universal_shift_register_seq_if #(.WIDTH(8), .CNT_W(4)) bus ();

    universal_shift_register_seq #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; compare q against the oldest queued expectation.
    task automatic tick(input string tag);
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=queued_value", tag, bus.q);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.q, e);
        end
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.op = 3'b000; bus.d = 8'h00; bus.sin_r = 1'b0;
        bus.sin_l = 1'b0; bus.start = 1'b0; bus.n = 4'd0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] exp,
                         input string tag);
        idle_inputs();
        bus.en = 1'b1; bus.op = op; bus.d = d;
        exp_q.push_back(exp);
        tick(tag);
    endtask

    initial begin
        // 1: reset with garbage inputs, including start
        rst = 1'b1;
        bus.en = 1'b1; bus.op = 3'b001; bus.d = 8'hFF; bus.sin_r = 1'b1;
        bus.sin_l = 1'b1; bus.start = 1'b1; bus.n = 4'd3;
        exp_q.push_back(8'h00);
        tick("reset_q");
        check("reset_qbar", bus.q_bar, 8'hFF);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        rst = 1'b0;
        idle_inputs();

        // 2: load, shift left, hold
        do_op(3'b001, 8'hA5, 8'hA5, "load_a5");
        idle_inputs();
        bus.en = 1'b1; bus.op = 3'b010; bus.sin_r = 1'b1;
        exp_q.push_back(8'h4B);
        tick("shl_4b");
        check("shl_sout_l", bus.sout_l, 1'b0);
        check("shl_sout_r", bus.sout_r, 1'b1);
        idle_inputs();
        bus.op = 3'b001; bus.d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h4B);
            tick("en0_hold");
        end

        // 3: ror, asr, shr, clear
        do_op(3'b001, 8'h81, 8'h81, "load_81");
        do_op(3'b101, 8'h00, 8'hC0, "ror_c0");
        do_op(3'b001, 8'h80, 8'h80, "load_80");
        do_op(3'b110, 8'h00, 8'hC0, "asr_c0");
        do_op(3'b011, 8'h00, 8'h60, "shr_60");
        do_op(3'b111, 8'h5A, 8'h00, "clear_00");

        // 4: sequenced rol x3, start/en pulsed while busy
        do_op(3'b001, 8'h96, 8'h96, "load_96");
        idle_inputs();
        bus.start = 1'b1; bus.op = 3'b100; bus.n = 4'd3;
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hB4);
        tick("rol_run1");
        check("rol_busy1", bus.busy, 1'b1);
        check("rol_done1", bus.done, 1'b0);
        bus.start = 1'b1; bus.en = 1'b1; bus.op = 3'b111; bus.n = 4'd7;
        tick("rol_run2");
        check("rol_busy2", bus.busy, 1'b1);
        tick("rol_run3");
        check("rol_busy3", bus.busy, 1'b0);
        check("rol_done3", bus.done, 1'b1);
        idle_inputs();
        exp_q.push_back(8'hB4);
        tick("rol_after");
        check("rol_done_clr", bus.done, 1'b0);

        // 5: run aborted by reset, then a fresh start
        do_op(3'b001, 8'h01, 8'h01, "load_01");
        idle_inputs();
        bus.start = 1'b1; bus.op = 3'b010; bus.n = 4'd5; bus.sin_r = 1'b0;
        exp_q.push_back(8'h02);
        tick("abort_s1");
        bus.start = 1'b0;
        exp_q.push_back(8'h04);
        tick("abort_s2");
        check("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        exp_q.push_back(8'h00);
        tick("abort_rst_q");
        check("abort_busy", bus.busy, 1'b0);
        rst = 1'b0;
        exp_q.push_back(8'h00);
        tick("abort_idle");
        check("abort_no_done", bus.done, 1'b0);
        idle_inputs();
        bus.start = 1'b1; bus.op = 3'b001; bus.d = 8'h3C; bus.n = 4'd1;
        exp_q.push_back(8'h3C);
        tick("restart_load");
        check("restart_done", bus.done, 1'b1);
        check("restart_busy", bus.busy, 1'b0);

        // 6: n==0 start, then back-to-back run started in the FIN cycle
        idle_inputs();
        bus.start = 1'b1; bus.op = 3'b010; bus.n = 4'd0; bus.sin_r = 1'b1;
        exp_q.push_back(8'h3C);
        tick("n0_q");
        check("n0_busy", bus.busy, 1'b0);
        check("n0_done", bus.done, 1'b1);
        bus.start = 1'b1; bus.op = 3'b011; bus.n = 4'd2; bus.sin_l = 1'b1;
        exp_q.push_back(8'h9E);
        exp_q.push_back(8'hCF);
        tick("b2b_s1");
        check("b2b_busy", bus.busy, 1'b1);
        check("b2b_done_low", bus.done, 1'b0);
        bus.start = 1'b0;
        tick("b2b_s2");
        check("b2b_done", bus.done, 1'b1);
        idle_inputs();
        exp_q.push_back(8'hCF);
        tick("b2b_idle");
        check("b2b_done_clr", bus.done, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/universal_shift_register_seq.md
Name: universal_shift_register_seq

Overview:
Parametrised successor to the single-bit D flip-flop with synchronous reset: a WIDTH-bit register with complementary outputs and eight operating modes (hold, load, clear, logical/arithmetic shifts, rotates). It adds a multi-cycle sequencer that performs N consecutive shifts from one start pulse, with busy/done status. It is used as the general storage and serialisation element in the datapath labs.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 4, width of shift-count input n; max run length 2^CNT_W - 1
RESET_VAL, 0, value of q after reset (WIDTH bits)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
en  input  1  single-cycle op enable (used only when sequencer idle)
op  input  3  000 hold, 001 load d, 010 shl, 011 shr, 100 rol, 101 ror, 110 asr, 111 clear
d  input  WIDTH  parallel load data
sin_r  input  1  serial bit entering LSB on shl
sin_l  input  1  serial bit entering MSB on shr
start  input  1  begin sequenced run of op, n times
n  input  CNT_W  run length, sampled with start
q  output  WIDTH  register contents
q_bar  output  WIDTH  bitwise complement of q
sout_l  output  1  q[WIDTH-1]
sout_r  output  1  q[0]
busy  output  1  sequenced run in progress
done  output  1  one-cycle pulse at end of a run

Behaviour:
- Reset (rst=1 at rising edge): q=RESET_VAL, state=IDLE, busy=0, done=0, counter=0. Reset overrides all other inputs, including mid-run; an aborted run produces no done pulse.
- q_bar, sout_l, sout_r are combinational from q. All other outputs are registered.
- Op semantics (one step): hold q=q; load q=d; shl q={q[W-2:0],sin_r}; shr q={sin_l,q[W-1:1]}; rol q={q[W-2:0],q[W-1]}; ror q={q[0],q[W-1:1]}; asr q={q[W-1],q[W-1:1]}; clear q=0.
- States: IDLE, RUN, FIN.
- IDLE/FIN, start=1: op and n are latched.
  - If op is a shift type (010-110) and n>0: perform one step this edge. If n==1, go to FIN; otherwise remaining=n-1 and go to RUN.
  - If n==0 or op is hold/load/clear: perform the op once (n==0 leaves q unchanged), then go to FIN.
- IDLE/FIN, start=0, en=1: perform op once; no state change other than FIN->IDLE; done is not pulsed.
- IDLE/FIN, start=0, en=0: q holds. FIN always moves to IDLE unless a new start is accepted.
- start has priority over en.
- RUN: each edge performs the latched op with live sin_l/sin_r and decrements remaining. When remaining reaches 0 after a step, go to FIN. start, en, op and n are ignored in RUN.
- busy=1 exactly while state==RUN. done=1 exactly while state==FIN.
- Latency: a run of n shifts has q final n edges after the start edge. done is high in the cycle following the last shift edge. A new start is accepted in the FIN cycle (back-to-back runs).
- Counter width is CNT_W. No wrap occurs because n is at most 2^CNT_W-1.

Test Plan:
1. rst=1 for one edge with garbage inputs -> q=00, q_bar=FF, busy=0, done=0; rst in the same cycle as start leaves busy=0.
2. en=1 op=001 d=A5 -> q=A5; next cycle op=010 sin_r=1 -> q=4B, sout_l=0, sout_r=1; en=0 for 3 cycles -> q stays 4B.
3. Load 81, op=101 (ror) -> q=C0. Load 80, op=110 (asr) -> q=C0. op=011 (shr) sin_l=0 on C0 -> 60. op=111 -> 00.
4. Load 96, start op=100 (rol) n=3 -> q=2D,5A,B4 on consecutive edges. busy=1 for 2 cycles, done=1 for 1 cycle with q=B4. start/en pulsed during busy have no effect.
5. start op=010 n=5 from q=01, sin_r=0, rst asserted after 2 shifts (q=04) -> q=00, busy=0, no done pulse; a subsequent start works normally.
6. start n=0 op=010 -> q unchanged, busy never 1, done pulse next cycle. start in the FIN cycle with op=011 n=2 -> second run executes back-to-back, then done pulses again.
